// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered N-channel multiplexer with valid/ready on every input
// and on the output. Arbitration is fixed-priority (lowest index wins) or
// round-robin from a rotating pointer. The winning word and its channel index
// pass through a one-deep output register.
module rr_mux_reg #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [CH_W-1:0]  r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [CH_W-1:0]  r_out_ch;
    logic             r_out_valid;

    logic             w_load_en;
    logic             w_found;
    logic [CH_W-1:0]  w_grant_idx;
    logic             w_xfer;
    logic [CH_W-1:0]  w_ptr_next;
    int               w_base;
    int               w_idx;

    // The output register can take a word when empty or draining this cycle.
    assign w_load_en = ~r_out_valid | out_ready;

    // Search for the first requester, from channel 0 (mode 0) or from the pointer (mode 1).
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_base      = mode ? int'(r_ptr) : 0;
        w_idx       = 0;
        for (int off = 0; off < N_CH; off++) begin
            w_idx = w_base + off;
            if (w_idx >= N_CH) begin
                w_idx = w_idx - N_CH;
            end
            if (!w_found && in_valid[w_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = CH_W'(w_idx);
            end
        end
    end

    // A transfer happens only when the register can load and reset is not asserted.
    assign w_xfer     = w_found & w_load_en & ~rst;
    assign in_ready   = w_xfer ? (N_CH'(1) << w_grant_idx) : '0;
    assign w_ptr_next = (w_grant_idx == CH_W'(N_CH - 1)) ? '0 : w_grant_idx + CH_W'(1);

    // Output register and round-robin pointer; reset wins over a simultaneous transfer.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_grant_idx*WIDTH +: WIDTH];
            r_out_ch    <= w_grant_idx;
            r_ptr       <= w_ptr_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
